pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken-branch redirects.
- Runs a req/ack handshake with a multi-cycle data memory, freezing the pipeline until it completes.
- Sits beside the pipeline registers. State updates on posedge CLK; pipeline registers capture on negedge CLK, so all combinational outputs must settle within half a cycle.

---
 rtl/pipeline_hazard_controller.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, DMEM handshake.
// Optional PERF_COUNTERS_EN adds saturating stall-cycle and flush counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MemRead,
  input  logic                  EX_BRANCH_TAKEN,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemWrite,
  input  logic                  DMEM_ACK,
  output logic                  DMEM_REQ,
  output logic                  PC_EN,
  output logic                  IF_ID_EN,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_FLUSH,
  output logic                  EX_MEM_EN,
  output logic                  MEM_WB_EN,
  output logic                  MEM_WB_BUBBLE,
  output logic                  DMEM_TIMEOUT,
  output logic [31:0]           STALL_CYCLES,
  output logic [31:0]           FLUSH_COUNT
);

  // state    | meaning
  // RUN      | pipeline flowing; hazards and branches evaluated
  // WAIT_ACK | DMEM request outstanding, pipeline frozen
  // FAULT    | DMEM never answered; frozen until reset
  typedef enum logic [1:0] {RUN = 2'd0, WAIT_ACK = 2'd1, FAULT = 2'd2} stateT;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  stateT      state, stateNext;
  logic [7:0] wcnt, wcntNext;
  logic       memOp, memStall, loadUse;

  assign memOp    = MEM_MemRead | MEM_MemWrite;
  assign memStall = ((state == RUN) && memOp && !DMEM_ACK) ||
                    ((state == WAIT_ACK) && !DMEM_ACK);
  assign loadUse  = EX_MemRead && (EX_RD != '0) &&
                    ((EX_RD == ID_RS1) || (ID_USES_RS2 && (EX_RD == ID_RS2)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= stateNext;
      wcnt  <= wcntNext;
    end
  end

  always_comb begin
    stateNext = state;
    wcntNext  = wcnt;
    case (state)
      RUN: begin
        if (memOp && !DMEM_ACK) begin
          stateNext = WAIT_ACK;
          wcntNext  = 8'd1;
        end
      end
      WAIT_ACK: begin
        if (DMEM_ACK) begin
          stateNext = RUN;
          wcntNext  = 8'd0;
        end else if (wcnt == TIMEOUT_CNT) begin
          stateNext = FAULT;
        end else begin
          wcntNext = wcnt + 8'd1;
        end
      end
      FAULT: stateNext = FAULT;
      default: begin
        stateNext = RUN;
        wcntNext  = 8'd0;
      end
    endcase
  end

  always_comb begin
    DMEM_REQ      = 1'b0;
    PC_EN         = 1'b1;
    IF_ID_EN      = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_EN     = 1'b1;
    MEM_WB_EN     = 1'b1;
    MEM_WB_BUBBLE = 1'b0;
    if (RST) begin
      PC_EN         = 1'b0;
      IF_ID_EN      = 1'b0;
      EX_MEM_EN     = 1'b0;
      MEM_WB_EN     = 1'b0;
      IF_ID_FLUSH   = 1'b1;
      ID_EX_FLUSH   = 1'b1;
      MEM_WB_BUBBLE = 1'b1;
    end else if (state == FAULT) begin
      PC_EN         = 1'b0;
      IF_ID_EN      = 1'b0;
      EX_MEM_EN     = 1'b0;
      MEM_WB_EN     = 1'b0;
      MEM_WB_BUBBLE = 1'b1;
    end else begin
      DMEM_REQ = (state == WAIT_ACK) || memOp;
      // ID/EX holds during a mem-stall; MEM/WB keeps swallowing bubbles
      if (memStall) begin
        PC_EN         = 1'b0;
        IF_ID_EN      = 1'b0;
        EX_MEM_EN     = 1'b0;
        MEM_WB_BUBBLE = 1'b1;
      end else if (EX_BRANCH_TAKEN) begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
      end else if (loadUse) begin
        PC_EN       = 1'b0;
        IF_ID_EN    = 1'b0;
        ID_EX_FLUSH = 1'b1;
      end
    end
  end

  assign DMEM_TIMEOUT = (state == FAULT);

`ifdef PERF_COUNTERS_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stallCnt <= 32'd0;
      flushCnt <= 32'd0;
    end else begin
      if (!PC_EN && (state != FAULT) && (stallCnt != 32'hFFFF_FFFF))
        stallCnt <= stallCnt + 32'd1;
      if (IF_ID_FLUSH && (flushCnt != 32'hFFFF_FFFF))
        flushCnt <= flushCnt + 32'd1;
    end
  end

  assign STALL_CYCLES = stallCnt;
  assign FLUSH_COUNT  = flushCnt;
`else
  assign STALL_CYCLES = 32'd0;
  assign FLUSH_COUNT  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; expectations are hand-computed per vector.
module tb_pipeline_hazard_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  ID_RS1, ID_RS2, EX_RD;
  logic        ID_USES_RS2, EX_MemRead, EX_BRANCH_TAKEN;
  logic        MEM_MemRead, MEM_MemWrite, DMEM_ACK;
  logic        DMEM_REQ, PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_FLUSH;
  logic        EX_MEM_EN, MEM_WB_EN, MEM_WB_BUBBLE, DMEM_TIMEOUT;
  logic [31:0] STALL_CYCLES, FLUSH_COUNT;

  int cmpCount = 0;
  int errCount = 0;

`ifdef PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipeline_hazard_controller #(.MEM_TIMEOUT(15), .REG_ADDR_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD(EX_RD), .EX_MemRead(EX_MemRead), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .DMEM_ACK(DMEM_ACK),
    .DMEM_REQ(DMEM_REQ), .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN), .MEM_WB_BUBBLE(MEM_WB_BUBBLE),
    .DMEM_TIMEOUT(DMEM_TIMEOUT), .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    cmpCount++;
    if (obs !== expVal) begin
      errCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expVal);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_USES_RS2 = 1'b0;
    EX_RD = 5'd0; EX_MemRead = 1'b0; EX_BRANCH_TAKEN = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; DMEM_ACK = 1'b0;
  endtask

  task automatic checkRunDefault(input string tag);
    checkResult({tag, "_pc_en"}, 32'(PC_EN), 32'd1);
    checkResult({tag, "_if_id_en"}, 32'(IF_ID_EN), 32'd1);
    checkResult({tag, "_ex_mem_en"}, 32'(EX_MEM_EN), 32'd1);
    checkResult({tag, "_mem_wb_en"}, 32'(MEM_WB_EN), 32'd1);
    checkResult({tag, "_if_id_flush"}, 32'(IF_ID_FLUSH), 32'd0);
    checkResult({tag, "_id_ex_flush"}, 32'(ID_EX_FLUSH), 32'd0);
    checkResult({tag, "_bubble"}, 32'(MEM_WB_BUBBLE), 32'd0);
  endtask

  task automatic checkMemStall(input string tag);
    checkResult({tag, "_req"}, 32'(DMEM_REQ), 32'd1);
    checkResult({tag, "_pc_en"}, 32'(PC_EN), 32'd0);
    checkResult({tag, "_if_id_en"}, 32'(IF_ID_EN), 32'd0);
    checkResult({tag, "_ex_mem_en"}, 32'(EX_MEM_EN), 32'd0);
    checkResult({tag, "_mem_wb_en"}, 32'(MEM_WB_EN), 32'd1);
    checkResult({tag, "_bubble"}, 32'(MEM_WB_BUBBLE), 32'd1);
    checkResult({tag, "_id_ex_flush"}, 32'(ID_EX_FLUSH), 32'd0);
    checkResult({tag, "_if_id_flush"}, 32'(IF_ID_FLUSH), 32'd0);
  endtask

  initial begin
    clearInputs();
    RST = 1'b1;

    // reset held two cycles, with a mem op pending to prove the override
    MEM_MemRead = 1'b1;
    step();
    step();
    checkResult("rst_pc_en", 32'(PC_EN), 32'd0);
    checkResult("rst_if_id_flush", 32'(IF_ID_FLUSH), 32'd1);
    checkResult("rst_id_ex_flush", 32'(ID_EX_FLUSH), 32'd1);
    checkResult("rst_bubble", 32'(MEM_WB_BUBBLE), 32'd1);
    checkResult("rst_mem_wb_en", 32'(MEM_WB_EN), 32'd0);
    checkResult("rst_req", 32'(DMEM_REQ), 32'd0);
    checkResult("rst_timeout", 32'(DMEM_TIMEOUT), 32'd0);
    checkResult("rst_stall_cnt", STALL_CYCLES, 32'd0);
    MEM_MemRead = 1'b0;
    RST = 1'b0;
    #1;
    checkRunDefault("idle");
    checkResult("idle_req", 32'(DMEM_REQ), 32'd0);

    // memory wait: ack arrives in the fourth request cycle
    step();
    MEM_MemRead = 1'b1;
    #1 checkMemStall("mw0");
    step();
    EX_BRANCH_TAKEN = 1'b1; ID_RS1 = 5'd4; EX_RD = 5'd4; EX_MemRead = 1'b1;
    #1 checkMemStall("mw1_ignore_events");
    step();
    EX_BRANCH_TAKEN = 1'b0; EX_MemRead = 1'b0;
    #1 checkMemStall("mw2");
    step();
    DMEM_ACK = 1'b1;
    #1 checkResult("mw3_req", 32'(DMEM_REQ), 32'd1);
    checkRunDefault("mw3_ack");
    step();
    clearInputs();
    #1 checkResult("mw_done_req", 32'(DMEM_REQ), 32'd0);
    checkRunDefault("mw_done");
    checkResult("mw_stall_cnt", STALL_CYCLES, PERF ? 32'd3 : 32'd0);

    // zero-stall access
    MEM_MemWrite = 1'b1; DMEM_ACK = 1'b1;
    #1 checkResult("zs_req", 32'(DMEM_REQ), 32'd1);
    checkRunDefault("zs");
    step();
    clearInputs();
    #1 checkRunDefault("zs_after");
    checkResult("zs_after_req", 32'(DMEM_REQ), 32'd0);

    // load-use via rs2: exactly one bubble
    EX_MemRead = 1'b1; EX_RD = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1; ID_RS1 = 5'd3;
    #1 checkResult("lu2_pc_en", 32'(PC_EN), 32'd0);
    checkResult("lu2_if_id_en", 32'(IF_ID_EN), 32'd0);
    checkResult("lu2_id_ex_flush", 32'(ID_EX_FLUSH), 32'd1);
    checkResult("lu2_ex_mem_en", 32'(EX_MEM_EN), 32'd1);
    checkResult("lu2_mem_wb_en", 32'(MEM_WB_EN), 32'd1);
    checkResult("lu2_if_id_flush", 32'(IF_ID_FLUSH), 32'd0);
    step();
    EX_MemRead = 1'b0; EX_RD = 5'd0;
    #1 checkRunDefault("lu2_after");

    // load-use via rs1
    EX_MemRead = 1'b1; EX_RD = 5'd7; ID_RS1 = 5'd7; ID_USES_RS2 = 1'b0; ID_RS2 = 5'd1;
    #1 checkResult("lu1_pc_en", 32'(PC_EN), 32'd0);
    checkResult("lu1_id_ex_flush", 32'(ID_EX_FLUSH), 32'd1);
    step();

    // rs2 matches but is not read
    EX_RD = 5'd9; ID_RS1 = 5'd2; ID_RS2 = 5'd9; ID_USES_RS2 = 1'b0;
    #1 checkRunDefault("lu_nors2");

    // x0 never hazards
    EX_RD = 5'd0; ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_USES_RS2 = 1'b1;
    #1 checkRunDefault("lu_x0");

    // non-load producer never hazards
    EX_MemRead = 1'b0; EX_RD = 5'd6; ID_RS1 = 5'd6;
    #1 checkRunDefault("lu_noload");

    // branch overrides load-use
    EX_MemRead = 1'b1; EX_RD = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1; EX_BRANCH_TAKEN = 1'b1;
    #1 checkResult("br_if_id_flush", 32'(IF_ID_FLUSH), 32'd1);
    checkResult("br_id_ex_flush", 32'(ID_EX_FLUSH), 32'd1);
    checkResult("br_pc_en", 32'(PC_EN), 32'd1);
    checkResult("br_if_id_en", 32'(IF_ID_EN), 32'd1);
    checkResult("br_ex_mem_en", 32'(EX_MEM_EN), 32'd1);
    step();
    clearInputs();
    #1 checkRunDefault("br_after");
    checkResult("br_flush_cnt", FLUSH_COUNT, PERF ? 32'd1 : 32'd0);
    checkResult("br_stall_cnt", STALL_CYCLES, PERF ? 32'd5 : 32'd0);

    // timeout: 16 stalled request cycles, then FAULT
    MEM_MemWrite = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 checkResult($sformatf("to_req_%0d", i), 32'(DMEM_REQ), 32'd1);
      checkResult($sformatf("to_pc_en_%0d", i), 32'(PC_EN), 32'd0);
      checkResult($sformatf("to_flag_%0d", i), 32'(DMEM_TIMEOUT), 32'd0);
      step();
    end
    #1 checkResult("fault_flag", 32'(DMEM_TIMEOUT), 32'd1);
    checkResult("fault_req", 32'(DMEM_REQ), 32'd0);
    checkResult("fault_pc_en", 32'(PC_EN), 32'd0);
    checkResult("fault_if_id_en", 32'(IF_ID_EN), 32'd0);
    checkResult("fault_ex_mem_en", 32'(EX_MEM_EN), 32'd0);
    checkResult("fault_mem_wb_en", 32'(MEM_WB_EN), 32'd0);
    checkResult("fault_bubble", 32'(MEM_WB_BUBBLE), 32'd1);
    MEM_MemWrite = 1'b0; DMEM_ACK = 1'b1;
    step();
    step();
    step();
    checkResult("fault_sticky", 32'(DMEM_TIMEOUT), 32'd1);
    checkResult("fault_sticky_pc_en", 32'(PC_EN), 32'd0);
    checkResult("fault_stall_cnt", STALL_CYCLES, PERF ? 32'd21 : 32'd0);
    DMEM_ACK = 1'b0;

    // reset clears the fault and the counters
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1 checkResult("rec_flag", 32'(DMEM_TIMEOUT), 32'd0);
    checkRunDefault("rec");
    checkResult("rec_stall_cnt", STALL_CYCLES, 32'd0);
    checkResult("rec_flush_cnt", FLUSH_COUNT, 32'd0);

    // reset during WAIT_ACK drops the request at once
    step();
    MEM_MemRead = 1'b1;
    step();
    #1 checkResult("mid_wait_req", 32'(DMEM_REQ), 32'd1);
    RST = 1'b1;
    #1 checkResult("mid_rst_req", 32'(DMEM_REQ), 32'd0);
    step();
    RST = 1'b0; MEM_MemRead = 1'b0;
    #1 checkResult("mid_after_req", 32'(DMEM_REQ), 32'd0);
    checkRunDefault("mid_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
